// File: rtl/rtc_wr_seq.sv
// rtl/rtc_wr_seq.sv - two-phase (address, then data) write sequencer for the RTC multiplexed AD bus.
// Optional one-entry pending request buffer: define RTC_WR_QUEUE_EN.
module rtc_wr_seq #(
    parameter int PHASE_CYC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       ad_oe,
    output logic [7:0] ad_out,
    output logic       busy,
    output logic       done,
    output logic       q_full
);

    localparam int CW = $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] A_SETUP = 3'd1;
    localparam logic [2:0] A_STRB  = 3'd2;
    localparam logic [2:0] A_HOLD  = 3'd3;
    localparam logic [2:0] D_SETUP = 3'd4;
    localparam logic [2:0] D_STRB  = 3'd5;
    localparam logic [2:0] D_HOLD  = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    addr_q, data_q, addr_nx, data_nx;
    logic          load_cur;

    logic          cs_n_nx, a_d_nx, ad_oe_nx, busy_nx, done_nx;
    logic [7:0]    ad_out_nx;
    logic          a_phase, d_phase;

`ifdef RTC_WR_QUEUE_EN
    logic [7:0] slot_addr, slot_data;
    logic       q_full_r;
    logic       load_slot, slot_set, slot_clr;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_cur = 1'b0;
`ifdef RTC_WR_QUEUE_EN
        load_slot = 1'b0;
        slot_set  = 1'b0;
        slot_clr  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = A_SETUP;
                    cnt_nx   = RELOAD;
                    load_cur = 1'b1;
                end
            end
            A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD: begin
                if (cnt == '0) begin
                    state_nx = state + 3'd1;
                    cnt_nx   = RELOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
`ifdef RTC_WR_QUEUE_EN
                // A held request wins over a fresh start arriving in the same cycle.
                if (q_full_r) begin
                    state_nx  = A_SETUP;
                    cnt_nx    = RELOAD;
                    load_slot = 1'b1;
                    slot_clr  = 1'b1;
                end else if (start) begin
                    state_nx = A_SETUP;
                    cnt_nx   = RELOAD;
                    load_cur = 1'b1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
`ifdef RTC_WR_QUEUE_EN
        if (start && !q_full_r && state != IDLE && state != DONE)
            slot_set = 1'b1;
`endif
    end

    always_comb begin
        addr_nx = addr_q;
        data_nx = data_q;
        if (load_cur) begin
            addr_nx = addr;
            data_nx = data;
        end
`ifdef RTC_WR_QUEUE_EN
        else if (load_slot) begin
            addr_nx = slot_addr;
            data_nx = slot_data;
        end
`endif
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        a_phase   = (state_nx == A_SETUP) || (state_nx == A_STRB) || (state_nx == A_HOLD);
        d_phase   = (state_nx == D_SETUP) || (state_nx == D_STRB) || (state_nx == D_HOLD);
        cs_n_nx   = !((state_nx == A_STRB) || (state_nx == D_STRB));
        a_d_nx    = !a_phase;
        ad_oe_nx  = a_phase || d_phase;
        ad_out_nx = 8'h00;
        if (a_phase)
            ad_out_nx = addr_nx;
        else if (d_phase)
            ad_out_nx = data_nx;
        busy_nx   = (state_nx != IDLE);
        done_nx   = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
            cs_n   <= cs_n_nx;
            wr_n   <= cs_n_nx;
            a_d    <= a_d_nx;
            ad_oe  <= ad_oe_nx;
            ad_out <= ad_out_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

`ifdef RTC_WR_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            q_full_r  <= 1'b0;
            slot_addr <= 8'h00;
            slot_data <= 8'h00;
        end else if (slot_set) begin
            q_full_r  <= 1'b1;
            slot_addr <= addr;
            slot_data <= data;
        end else if (slot_clr) begin
            q_full_r <= 1'b0;
        end
    end

    assign q_full = q_full_r;
`else
    assign q_full = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_wr_seq.sv
// tb/tb_rtc_wr_seq.sv - directed self-checking bench for rtc_wr_seq.
module tb_rtc_wr_seq;

`ifdef RTC_WR_QUEUE_EN
    localparam int P = 1;
`else
    localparam int P = 2;
`endif
    localparam int N = 6 * P + 1;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] addr, data;
    logic       cs_n, wr_n, a_d, ad_oe, busy, done, q_full;
    logic [7:0] ad_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rtc_wr_seq #(.PHASE_CYC(P)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .cs_n(cs_n), .wr_n(wr_n), .a_d(a_d), .ad_oe(ad_oe), .ad_out(ad_out),
        .busy(busy), .done(done), .q_full(q_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [13:0] obs = {cs_n, wr_n, a_d, ad_oe, ad_out, busy, done};

    // Expected {cs_n,wr_n,a_d,ad_oe,ad_out,busy,done} for cycle i after the accepting edge.
    function automatic logic [13:0] exp_vec(int i, logic [7:0] a, logic [7:0] d);
        int   ph;
        logic strb, dph;
        if (i > N) return {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        if (i == N) return {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        ph   = (i - 1) / P;
        strb = (ph == 1) || (ph == 4);
        dph  = (ph >= 3);
        return {~strb, ~strb, dph, 1'b1, (dph ? d : a), 1'b1, 1'b0};
    endfunction

    // a_d is left unchecked in the DONE cycle.
    function automatic logic [13:0] mask_for(int i);
        return (i == N) ? 14'h37FF : 14'h3FFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; addr = 8'h00; data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if ((obs !== exp_vec(N + 1, 8'h00, 8'h00)) || (q_full !== 1'b0)) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h q_full=%b exp=%h q_full=0", i, obs, q_full, exp_vec(N + 1, 8'h00, 8'h00));
            end
            tick();
        end
    endtask

`ifdef RTC_WR_QUEUE_EN
    task automatic test_queue();
        logic [13:0] e;
        logic        eq;
        addr = 8'h10; data = 8'h01; start = 1'b1;
        tick();
        start = 1'b0; addr = 8'hFF; data = 8'hEE;
        for (int i = 1; i <= 2 * N + 1; i++) begin
            if (i <= N) e = exp_vec(i, 8'h10, 8'h01);
            else        e = exp_vec(i - N, 8'h11, 8'h02);
            total++;
            if ((obs & mask_for((i - 1) % N + 1)) !== (e & mask_for((i - 1) % N + 1))) begin
                bad++;
                $display("FAIL queue_seq i=%0d got=%h exp=%h", i, obs, e);
            end
            eq = (i >= 4) && (i <= N);
            total++;
            if (q_full !== eq) begin
                bad++;
                $display("FAIL queue_full i=%0d got=%b exp=%b", i, q_full, eq);
            end
            start = (i == 3);
            addr  = (i == 3) ? 8'h11 : 8'hFF;
            data  = (i == 3) ? 8'h02 : 8'hEE;
            tick();
        end
    endtask
`else
    task automatic test_basic();
        addr = 8'h21; data = 8'h45; start = 1'b1;
        tick();
        start = 1'b0; addr = 8'hFF; data = 8'h00;
        for (int i = 1; i <= N + 1; i++) begin
            total++;
            if ((obs & mask_for(i)) !== (exp_vec(i, 8'h21, 8'h45) & mask_for(i))) begin
                bad++;
                $display("FAIL basic i=%0d got=%h exp=%h", i, obs, exp_vec(i, 8'h21, 8'h45));
            end
            tick();
        end
    endtask

    task automatic test_ignore();
        addr = 8'h21; data = 8'h45; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= N + 1; i++) begin
            total++;
            if (((obs & mask_for(i)) !== (exp_vec(i, 8'h21, 8'h45) & mask_for(i))) || (q_full !== 1'b0)) begin
                bad++;
                $display("FAIL ignore_busy i=%0d got=%h q_full=%b exp=%h", i, obs, q_full, exp_vec(i, 8'h21, 8'h45));
            end
            start = (i == P + 1) || (i == N);
            addr  = start ? 8'h99 : 8'hFF;
            data  = start ? 8'h66 : 8'h00;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (obs !== exp_vec(N + 1, 8'h00, 8'h00)) begin
                bad++;
                $display("FAIL ignore_after i=%0d got=%h exp=%h", i, obs, exp_vec(N + 1, 8'h00, 8'h00));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        addr = 8'h21; data = 8'h45; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4 * P + 1; i++) begin
            total++;
            if (obs !== exp_vec(i, 8'h21, 8'h45)) begin
                bad++;
                $display("FAIL mid_pre i=%0d got=%h exp=%h", i, obs, exp_vec(i, 8'h21, 8'h45));
            end
            if (i == 4 * P + 1) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        total++;
        if (obs !== exp_vec(N + 1, 8'h00, 8'h00)) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", obs, exp_vec(N + 1, 8'h00, 8'h00));
        end
        addr = 8'h5A; data = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= N + 1; i++) begin
            total++;
            if ((obs & mask_for(i)) !== (exp_vec(i, 8'h5A, 8'hC3) & mask_for(i))) begin
                bad++;
                $display("FAIL mid_restart i=%0d got=%h exp=%h", i, obs, exp_vec(i, 8'h5A, 8'hC3));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        t1 = -1000; t2 = 0;
        addr = 8'h33; data = 8'h44; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= N + 1; i++) begin
            total++;
            if ((obs & mask_for(i)) !== (exp_vec(i, 8'h33, 8'h44) & mask_for(i))) begin
                bad++;
                $display("FAIL b2b_first i=%0d got=%h exp=%h", i, obs, exp_vec(i, 8'h33, 8'h44));
            end
            if (done) t1 = cyc;
            if (i == N + 1) begin
                start = 1'b1; addr = 8'h55; data = 8'h66;
            end
            tick();
        end
        start = 1'b0;
        for (int i = 1; i <= N + 1; i++) begin
            total++;
            if ((obs & mask_for(i)) !== (exp_vec(i, 8'h55, 8'h66) & mask_for(i))) begin
                bad++;
                $display("FAIL b2b_second i=%0d got=%h exp=%h", i, obs, exp_vec(i, 8'h55, 8'h66));
            end
            if (done) t2 = cyc;
            tick();
        end
        total++;
        if (t2 - t1 != 14) begin
            bad++;
            $display("FAIL b2b_gap got=%0d exp=14", t2 - t1);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; addr = 8'h00; data = 8'h00;
        test_reset();
`ifdef RTC_WR_QUEUE_EN
        test_queue();
`else
        test_basic();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
